// File: rtl/l1i_arb_pkg.sv
// Shared types for the L1I request arbiter: slot owner, slot table entry, tag width.
package l1i_arb_pkg;

    // Default outstanding-request pool size; the slot struct sizes orig_tag from it.
    localparam int unsigned IFQ_DEPTH_DEFAULT = 4;
    localparam int unsigned IFQ_TAG_WIDTH     = $clog2(IFQ_DEPTH_DEFAULT);

    typedef enum logic {
        OWN_DMD = 1'b0,
        OWN_PF  = 1'b1
    } owner_e;

    typedef struct packed {
        logic                     busy;
        owner_e                   owner;
        logic                     killed;
        logic [IFQ_TAG_WIDTH-1:0] orig_tag;
    } slot_t;

endpackage

// File: rtl/l1i_slot_alloc.sv
// Free-slot priority encoder: reports whether any slot is free and the lowest free index.
module l1i_slot_alloc #(
    parameter int unsigned DEPTH = 4
) (
    input  logic [DEPTH-1:0]         busy_i,
    output logic                     found_o,
    output logic [$clog2(DEPTH)-1:0] idx_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    // Scan from the top down so the lowest free index is the last one written.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (!busy_i[i]) begin
                found_o = 1'b1;
                idx_o   = i[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/l1i_req_arbiter.sv
// Arbitrates demand fetch and next-line prefetch onto the single L1I request port,
// tracks each outstanding request in a slot table and routes responses to their owner.
module l1i_req_arbiter
    import l1i_arb_pkg::*;
#(
    parameter int unsigned L1I_INDEX_WIDTH  = 6,
    parameter int unsigned L1I_OFFSET_WIDTH = 4,
    parameter int unsigned L1I_TAG_WIDTH    = 22,
    parameter int unsigned FETCH_WIDTH      = 128,
    // Must match IFQ_DEPTH_DEFAULT in the package, which sizes the stored tag.
    parameter int unsigned IFQ_DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         dmd_req_vld_i,
    output logic                         dmd_req_rdy_o,
    input  logic [L1I_INDEX_WIDTH-1:0]   dmd_req_index_i,
    input  logic [L1I_OFFSET_WIDTH-1:0]  dmd_req_offset_i,
    input  logic [L1I_TAG_WIDTH-1:0]     dmd_req_vtag_i,
    input  logic [$clog2(IFQ_DEPTH)-1:0] dmd_req_if_tag_i,
    input  logic                         pf_req_vld_i,
    output logic                         pf_req_rdy_o,
    input  logic [L1I_INDEX_WIDTH-1:0]   pf_req_index_i,
    input  logic [L1I_OFFSET_WIDTH-1:0]  pf_req_offset_i,
    input  logic [L1I_TAG_WIDTH-1:0]     pf_req_vtag_i,
    output logic                         l1i_req_vld_o,
    input  logic                         l1i_req_rdy_i,
    output logic [L1I_INDEX_WIDTH-1:0]   l1i_req_index_o,
    output logic [L1I_OFFSET_WIDTH-1:0]  l1i_req_offset_o,
    output logic [L1I_TAG_WIDTH-1:0]     l1i_req_vtag_o,
    output logic [$clog2(IFQ_DEPTH)-1:0] l1i_req_if_tag_o,
    input  logic                         l1i_resp_vld_i,
    input  logic [$clog2(IFQ_DEPTH)-1:0] l1i_resp_if_tag_i,
    input  logic [FETCH_WIDTH-1:0]       l1i_resp_data_i,
    output logic                         dmd_resp_vld_o,
    output logic [$clog2(IFQ_DEPTH)-1:0] dmd_resp_if_tag_o,
    output logic                         pf_resp_vld_o,
    output logic [FETCH_WIDTH-1:0]       resp_data_o,
    output logic                         busy_o,
    output logic                         err_resp_o
);

    localparam int unsigned TAG_W    = $clog2(IFQ_DEPTH);
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    slot_t                slot_q [IFQ_DEPTH];
    slot_t                slot_d [IFQ_DEPTH];
    slot_t                hit;
    logic [IFQ_DEPTH-1:0] busy_vec;
    logic                 free_found;
    logic [TAG_W-1:0]     free_idx;
    logic [STARVE_W-1:0]  starve_q, starve_d;
    logic                 starve_hit, pf_sel, req_hs;
    logic                 dmd_vld_d, pf_vld_d, err_d;
    logic [TAG_W-1:0]     tag_d;
    logic [FETCH_WIDTH-1:0] data_d;

    // Busy bits of the pre-edge table feed the allocator and busy_o.
    always_comb begin
        for (int i = 0; i < int'(IFQ_DEPTH); i++) begin
            busy_vec[i] = slot_q[i].busy;
        end
    end

    assign busy_o = |busy_vec;

    l1i_slot_alloc #(
        .DEPTH (IFQ_DEPTH)
    ) u_slot_alloc (
        .busy_i  (busy_vec),
        .found_o (free_found),
        .idx_o   (free_idx)
    );

    // Combinational grant: demand first unless the waiting prefetch has been starved.
    always_comb begin
        starve_hit       = (starve_q == STARVE_W'(STARVE_LIMIT));
        pf_sel           = pf_req_vld_i & (~dmd_req_vld_i | starve_hit);
        l1i_req_vld_o    = (dmd_req_vld_i | pf_req_vld_i) & free_found & ~flush_i;
        req_hs           = l1i_req_vld_o & l1i_req_rdy_i;
        dmd_req_rdy_o    = req_hs & ~pf_sel;
        pf_req_rdy_o     = req_hs & pf_sel;
        l1i_req_index_o  = pf_sel ? pf_req_index_i  : dmd_req_index_i;
        l1i_req_offset_o = pf_sel ? pf_req_offset_i : dmd_req_offset_i;
        l1i_req_vtag_o   = pf_sel ? pf_req_vtag_i   : dmd_req_vtag_i;
        l1i_req_if_tag_o = free_idx;
    end

    // Starvation count: demand grants seen while a prefetch waits; held when nothing is granted.
    always_comb begin
        starve_d = starve_q;
        if (!pf_req_vld_i || pf_req_rdy_o) begin
            starve_d = '0;
        end else if (dmd_req_rdy_o && !starve_hit) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    // Table update order: response free, then flush kill, then allocation.
    always_comb begin
        slot_d    = slot_q;
        hit       = slot_q[l1i_resp_if_tag_i];
        dmd_vld_d = 1'b0;
        pf_vld_d  = 1'b0;
        err_d     = 1'b0;
        tag_d     = dmd_resp_if_tag_o;
        data_d    = resp_data_o;
        if (l1i_resp_vld_i) begin
            if (hit.busy) begin
                slot_d[l1i_resp_if_tag_i].busy   = 1'b0;
                slot_d[l1i_resp_if_tag_i].killed = 1'b0;
                if (!hit.killed && !flush_i) begin
                    dmd_vld_d = (hit.owner == OWN_DMD);
                    pf_vld_d  = (hit.owner == OWN_PF);
                    data_d    = l1i_resp_data_i;
                    if (hit.owner == OWN_DMD) begin
                        tag_d = hit.orig_tag;
                    end
                end
            end else begin
                err_d = 1'b1;
            end
        end
        if (flush_i) begin
            for (int i = 0; i < int'(IFQ_DEPTH); i++) begin
                if (slot_d[i].busy) begin
                    slot_d[i].killed = 1'b1;
                end
            end
        end
        // The allocated slot was free pre-edge, so it never collides with the freed one.
        if (req_hs) begin
            slot_d[free_idx].busy     = 1'b1;
            slot_d[free_idx].owner    = pf_sel ? OWN_PF : OWN_DMD;
            slot_d[free_idx].killed   = 1'b0;
            slot_d[free_idx].orig_tag = pf_sel ? '0 : dmd_req_if_tag_i;
        end
    end

    // State and registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(IFQ_DEPTH); i++) begin
                slot_q[i] <= '0;
            end
            starve_q          <= '0;
            dmd_resp_vld_o    <= 1'b0;
            pf_resp_vld_o     <= 1'b0;
            err_resp_o        <= 1'b0;
            dmd_resp_if_tag_o <= '0;
            resp_data_o       <= '0;
        end else begin
            for (int i = 0; i < int'(IFQ_DEPTH); i++) begin
                slot_q[i] <= slot_d[i];
            end
            starve_q          <= starve_d;
            dmd_resp_vld_o    <= dmd_vld_d;
            pf_resp_vld_o     <= pf_vld_d;
            err_resp_o        <= err_d;
            dmd_resp_if_tag_o <= tag_d;
            resp_data_o       <= data_d;
        end
    end

endmodule

// File: doc/l1i_req_arbiter.md
Name: l1i_req_arbiter

Overview:
- Shares the single L1I request port between the fetch demand path and the next-line instruction prefetcher.
- Allocates a downstream if_tag per outstanding request and records its owner.
- Routes each L1I response back to the owning requester with that requester's original tag.
- On a flush, drops responses for in-flight requests. Sits between the fetch unit, the prefetcher and the L1I cache.

Parameters:
L1I_INDEX_WIDTH, 6, cache set index width
L1I_OFFSET_WIDTH, 4, byte offset within line
L1I_TAG_WIDTH, 22, virtual tag width
FETCH_WIDTH, 128, response data width (one line)
IFQ_DEPTH, 4, outstanding downstream requests; power of 2, >=2
STARVE_LIMIT, 4, consecutive demand grants before the waiting prefetch is forced

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush_i  in  1  global trap/ret/predict-miss flush
dmd_req_vld_i  in  1  demand request valid
dmd_req_rdy_o  out  1  demand request accepted
dmd_req_index_i / offset_i / vtag_i  in  L1I_*_WIDTH  demand address
dmd_req_if_tag_i  in  $clog2(IFQ_DEPTH)  requester tag
pf_req_vld_i  in  1  prefetch request valid
pf_req_rdy_o  out  1  prefetch accepted
pf_req_index_i / offset_i / vtag_i  in  L1I_*_WIDTH  prefetch address
l1i_req_vld_o  out  1  downstream request valid
l1i_req_rdy_i  in  1  downstream ready
l1i_req_index_o / offset_o / vtag_o  out  L1I_*_WIDTH  granted address
l1i_req_if_tag_o  out  $clog2(IFQ_DEPTH)  allocated slot id
l1i_resp_vld_i  in  1  response valid
l1i_resp_if_tag_i  in  $clog2(IFQ_DEPTH)  response slot id
l1i_resp_data_i  in  FETCH_WIDTH  line data
dmd_resp_vld_o  out  1  demand response valid
dmd_resp_if_tag_o  out  $clog2(IFQ_DEPTH)  original demand tag
pf_resp_vld_o  out  1  prefetch fill response valid
resp_data_o  out  FETCH_WIDTH  forwarded line data (shared)
busy_o  out  1  any slot outstanding
err_resp_o  out  1  response to non-busy slot (1-cycle pulse)

Behaviour:
- Slot table: IFQ_DEPTH entries, each holding busy, owner (DMD/PF), killed, and orig_tag. On reset all slots are cleared; starve_cnt=0; all outputs 0.
- Request path is combinational. l1i_req_vld_o = (dmd_req_vld_i | pf_req_vld_i) & free_slot_exists & ~flush_i. The allocated slot is the lowest-index non-busy slot.
- Grant selection:
  - Demand wins, unless pf_req_vld_i & starve_cnt==STARVE_LIMIT; then prefetch wins.
  - Address/tag muxed from the winner. Winner's rdy_o = l1i_req_vld_o & l1i_req_rdy_i; the loser's rdy_o = 0.
- Starvation counter:
  - Increments on a demand grant while pf_req_vld_i=1, saturating at STARVE_LIMIT.
  - Clears on a prefetch grant, or on any cycle with pf_req_vld_i=0.
- Allocation on handshake, at the clock edge: busy=1, owner=winner, killed=0, orig_tag=dmd_req_if_tag_i (0 for prefetch).
- Response path, registered, 1-cycle latency:
  - A response hitting a busy, non-killed slot drives dmd_resp_vld_o or pf_resp_vld_o per owner on the next cycle, with resp_data_o and dmd_resp_if_tag_o registered.
  - The slot frees at that same edge.
- Killed slots: a response to a killed slot frees the slot with no upstream valid.
- Unexpected responses: a response to a non-busy slot is ignored; err_resp_o=1 for one cycle, and the table is unchanged.
- Flush:
  - All busy slots are marked killed at the edge.
  - No grant in the flush cycle.
  - Any registered resp_vld pending for the next cycle is suppressed.
- Same-cycle free and alloc: both apply at the edge. The free-slot search uses pre-edge state, so the freed slot is reusable only from the next cycle. Allocating and freeing the same slot in one cycle is impossible by construction.
- Full (all slots busy):
  - l1i_req_vld_o=0, both rdy_o=0.
  - starve_cnt holds.
- Reset mid-operation: the table is cleared. Responses arriving afterwards hit non-busy slots and raise err_resp_o. This is acceptable; the L1I is reset together with this block.
- busy_o = OR of all slot busy bits, registered view.

Decomposition:
- Package l1i_arb_pkg:
  - owner enum (OWN_DMD, OWN_PF);
  - slot struct {busy, owner, killed, orig_tag};
  - IFQ_TAG_WIDTH = $clog2(IFQ_DEPTH).
- One sub-module: l1i_slot_alloc, the free-slot priority encoder returning {found, index}, reusable by other tag pools.

Test Plan:
- Demand only, idx=0x05 if_tag=2, L1I resp tag 0 two cycles later → dmd_resp_vld_o=1 one cycle after resp, dmd_resp_if_tag_o=2, resp_data_o=resp data, busy_o back to 0.
- Demand and prefetch both held valid continuously, STARVE_LIMIT=4 → grant pattern D,D,D,D,P repeating; pf grant slot tag reflects lowest free slot.
- Four grants with no responses → fifth cycle l1i_req_vld_o=0, both rdy_o=0; respond to tag 1 → next cycle a new request is allocated tag 1.
- Two outstanding (tags 0,1), flush_i pulse, then responses tag 0 and tag 1 → no dmd/pf resp_vld, slots freed, busy_o=0, err_resp_o=0.
- Response with tag 3 while slot 3 not busy → err_resp_o one-cycle pulse, no upstream valid, table unchanged.
- Response to tag 0 plus new demand in the same cycle with slots 1-3 busy → no grant that cycle (full); grant to tag 0 the following cycle.
